// File: rtl/fns_dec_pipe.sv
// Pipelined Fibonacci-numeral-system decoder: N-bit FNS codeword -> binary, STAGES-deep with valid/ready.
// Define FNS_DEC_CHECK_EN to add the out_err port flagging non-canonical codewords (adjacent ones).
package fns_dec_pkg;
  function automatic logic [63:0] fib(input int k);
    logic [63:0] a, b, t;
    a = 64'd1;
    b = 64'd1;
    for (int i = 3; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Smallest width holding the largest decodable value F(n+3)-2.
  function automatic int fns_dw(input int n);
    logic [63:0] x;
    int r;
    x = fib(n + 3) - 64'd1;
    r = 0;
    for (int i = 0; i < 64; i++)
      if ((64'd1 << i) < x) r = i + 1;
    return r;
  endfunction
endpackage

module fns_dec_pipe
  import fns_dec_pkg::*;
#(
  parameter int N      = 42,
  parameter int STAGES = 3,
  localparam int DW    = fns_dw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  codein,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef FNS_DEC_CHECK_EN
  output logic          out_err,
`endif
  output logic [DW-1:0] dataout
);

  localparam int CHUNK = (N + STAGES - 1) / STAGES;

  function automatic logic [N*DW-1:0] wtab();
    logic [N*DW-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) w[i*DW +: DW] = DW'(fib(i + 2));
    return w;
  endfunction

  localparam logic [N*DW-1:0] WTAB = wtab();

  function automatic logic [DW-1:0] add_chunk(input logic [DW-1:0] s, input logic [N-1:0] c,
                                              input int k);
    logic [DW-1:0] acc;
    acc = s;
    for (int i = 0; i < N; i++)
      if (i >= k * CHUNK && i < (k + 1) * CHUNK && c[i]) acc = acc + WTAB[i*DW +: DW];
    return acc;
  endfunction

`ifdef FNS_DEC_CHECK_EN
  // Pair (i-1, i) belongs to the chunk owning bit i, so chunk-boundary pairs are covered too.
  function automatic logic chunk_err(input logic [N-1:0] c, input int k);
    logic e;
    e = 1'b0;
    for (int i = 1; i < N; i++)
      if (i >= k * CHUNK && i < (k + 1) * CHUNK && c[i] && c[i-1]) e = 1'b1;
    return e;
  endfunction

  logic [STAGES-1:0] err_p;
`endif

  logic [STAGES-1:0] vld_p;
  logic [DW-1:0]     sum_p  [STAGES];
  logic [N-1:0]      code_p [STAGES];
  logic [STAGES-1:0] adv;
  logic              adv_c;
  logic              unused_code;

  // Ready ripples back from the sink; a stage may load whenever it is empty or draining.
  always_comb begin
    adv = '0;
    adv_c = ~vld_p[STAGES-1] | out_ready;
    adv[STAGES-1] = adv_c;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_c = ~vld_p[k] | adv_c;
      adv[k] = adv_c;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_p[STAGES-1];
  assign dataout   = sum_p[STAGES-1];
`ifdef FNS_DEC_CHECK_EN
  assign out_err   = err_p[STAGES-1];
`endif

  // The full codeword rides along; already-consumed bits have no readers and are trimmed.
  always_comb begin
    unused_code = 1'b0;
    for (int k = 0; k < STAGES; k++) unused_code = unused_code ^ (^code_p[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
`ifdef FNS_DEC_CHECK_EN
      err_p <= '0;
`endif
      for (int k = 0; k < STAGES; k++) begin
        sum_p[k]  <= '0;
        code_p[k] <= '0;
      end
    end else begin
      // Stage 0: start the partial sum from the incoming codeword.
      if (adv[0]) begin
        vld_p[0]  <= in_valid & in_ready;
        sum_p[0]  <= add_chunk('0, codein, 0);
        code_p[0] <= codein;
`ifdef FNS_DEC_CHECK_EN
        err_p[0]  <= chunk_err(codein, 0);
`endif
      end
      // Stage k: fold chunk k into the partial sum carried from stage k-1.
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_p[k]  <= vld_p[k-1];
          sum_p[k]  <= add_chunk(sum_p[k-1], code_p[k-1], k);
          code_p[k] <= code_p[k-1];
`ifdef FNS_DEC_CHECK_EN
          err_p[k]  <= err_p[k-1] | chunk_err(code_p[k-1], k);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fns_dec_pipe.sv
// Scoreboard bench for fns_dec_pipe: N=42/STAGES=3 instance plus an N=8/STAGES=1 instance.
module tb_fns_dec_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [41:0] codein;
  logic [30:0] dataout;
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  codein8;
  logic [6:0]  dataout8;
`ifdef FNS_DEC_CHECK_EN
  logic        out_err, out_err8;
`endif

  fns_dec_pipe #(.N(42), .STAGES(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .codein(codein),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef FNS_DEC_CHECK_EN
    .out_err(out_err),
`endif
    .dataout(dataout));

  fns_dec_pipe #(.N(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .codein(codein8),
    .out_valid(out_valid8), .out_ready(out_ready8),
`ifdef FNS_DEC_CHECK_EN
    .out_err(out_err8),
`endif
    .dataout(dataout8));

  typedef struct {
    longint val;
    logic   err;
    int     acc;
    bit     lat;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic longint fns_ref(input logic [63:0] c, input int n);
    longint w0, w1, t, s;
    w0 = 1; w1 = 2; s = 0;
    for (int i = 0; i < n; i++) begin
      if (c[i]) s += w0;
      t = w0 + w1;
      w0 = w1;
      w1 = t;
    end
    return s;
  endfunction

  function automatic logic adj_ref(input logic [63:0] c);
    return |(c & (c >> 1));
  endfunction

  // Monitors: sample mid-low-phase, after stimulus settles, before the transfer edge.
  initial forever begin
    exp_t e;
    @(negedge clk); #2;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", {33'd0, dataout}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = q.pop_front();
        chk("dataout", {33'd0, dataout}, e.val);
`ifdef FNS_DEC_CHECK_EN
        chk("out_err", {63'd0, out_err}, {63'd0, e.err});
`endif
        if (e.lat) chk("latency", cyc - e.acc, 3);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk); #2;
    if (!rst && out_valid8 && out_ready8) begin
      if (q8.size() == 0) chk("spurious_out8", {57'd0, dataout8}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = q8.pop_front();
        chk("dataout8", {57'd0, dataout8}, e.val);
`ifdef FNS_DEC_CHECK_EN
        chk("out_err8", {63'd0, out_err8}, {63'd0, e.err});
`endif
        chk("latency8", cyc - e.acc, 1);
      end
    end
  end

  task automatic send(input logic [41:0] c, input longint v, input logic e, input bit lat,
                      input bit must_ready);
    int waits;
    @(negedge clk);
    in_valid = 1'b1;
    codein = c;
    #1;
    if (must_ready) chk("in_ready_stream", {63'd0, in_ready}, 64'd1);
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk); #1;
      waits++;
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    else q.push_back('{v, e, cyc, lat});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_valid8 = 1'b0;
    end
  endtask

  logic [41:0] vec_c [8];
  longint      vec_v [8];
  logic        vec_e [8];
  logic [41:0] bp [8];
  logic [41:0] rc;
  logic [30:0] hold;
  bit          have;
  int          idx;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_c = '{42'h0, 42'h1, 42'h2, 42'h15, 42'h200_0000_0000, 42'h3FF_FFFF_FFFF, 42'h3, 42'h6000};
    vec_v = '{0, 1, 2, 12, 433494437, 1134903168, 3, 1597};
    vec_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; codein = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; codein8 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_dataout", {33'd0, dataout}, 64'd0);
`ifdef FNS_DEC_CHECK_EN
    chk("reset_out_err", {63'd0, out_err}, 64'd0);
`endif
    rst = 1'b0;
    idle(2);

    // Directed values, back to back, no backpressure.
    for (int i = 0; i < 8; i++) send(vec_c[i], vec_v[i], vec_e[i], 1'b1, 1'b0);
    idle(6);

    // Random streaming: in_ready must never drop with out_ready held high.
    for (int i = 0; i < 100; i++) begin
      rc = {$urandom, $urandom};
      send(rc, fns_ref({22'd0, rc}, 42), adj_ref({22'd0, rc}), 1'b1, 1'b1);
    end
    idle(6);

    // Backpressure: 6 stalled cycles with in_valid held.
    for (int i = 0; i < 8; i++) bp[i] = {$urandom, $urandom};
    idx = 0; have = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      in_valid = 1'b1;
      codein = bp[idx];
      #1;
      if (in_ready) begin
        q.push_back('{fns_ref({22'd0, bp[idx]}, 42), adj_ref({22'd0, bp[idx]}), cyc, 1'b0});
        idx++;
      end
      if (out_valid) begin
        if (!have) begin hold = dataout; have = 1'b1; end
        else chk("stall_hold", {33'd0, dataout}, {33'd0, hold});
      end
      @(negedge clk);
    end
    #1;
    chk("bp_accepts", idx, 3);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 3; i < 8; i++)
      send(bp[i], fns_ref({22'd0, bp[i]}, 42), adj_ref({22'd0, bp[i]}), 1'b0, 1'b0);
    idle(8);

    // Reset with three codewords in flight.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vec_c[i+3], vec_v[i+3], vec_e[i+3], 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    idle(6);
    send(42'h15, 12, 1'b0, 1'b1, 1'b1);
    idle(6);

    // N=8, STAGES=1: every codeword, latency 1.
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      in_valid8 = 1'b1;
      codein8 = 8'(c);
      #1;
      chk("in_ready8", {63'd0, in_ready8}, 64'd1);
      q8.push_back('{fns_ref(64'(c), 8), adj_ref(64'(c)), cyc, 1'b1});
    end
    idle(4);

    for (int w = 0; w < 20 && (q.size() + q8.size()) != 0; w++) @(negedge clk);
    chk("queues_drained", q.size() + q8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fns_dec_pipe.md
Name: fns_dec_pipe

Overview:
- Parametrised, pipelined Fibonacci-numeral-system (FNS) decoder for the CAC receive path. Converts an N-bit FNS codeword to its binary value.
- Generalises the fixed 42-bit combinational FNS decoder in two ways: any codeword width, and a configurable number of pipeline stages with valid/ready backpressure.
- Sits between the CAC link deserialiser and the data sink.

Parameters:
- N, 42, codeword width in bits (N >= 2).
- STAGES, 3, number of pipeline stages (1 <= STAGES <= N). Each stage accumulates CHUNK = ceil(N/STAGES) codeword bits; the last stage takes the remainder.
- DW, localparam, output width = clog2(F(N+3)-1), computed by a constant function. The value is 31 for N=42.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept a codeword this cycle.
- codein  in  N  FNS codeword; bit i has weight F(i+2).
- out_valid  out  1  decoded value valid.
- out_ready  in  1  sink accepts the value this cycle.
- dataout  out  DW  decoded binary value.
- out_err  out  1  non-canonical codeword flag. Present only when FNS_DEC_CHECK_EN is defined.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Weights:
  - Fibonacci sequence with F(1)=F(2)=1. Bit i has weight F(i+2), so the weights run 1, 2, 3, 5, 8, ...
  - Weights are generated by a constant function at elaboration. There are no hard-coded tables.
- Pipeline structure:
  - Stage k holds three registers: a valid bit, a partial sum of DW bits, and the not-yet-consumed codeword bits.
  - Stage k adds the weighted bits [k*CHUNK, min((k+1)*CHUNK, N)-1] to the partial sum carried in from stage k-1. Stage 0 starts from a partial sum of 0.
- Arithmetic:
  - All additions are DW bits wide, unsigned.
  - Overflow is impossible by construction. The maximum value is F(N+3)-2, and DW is sized to hold it.
- Output: dataout, out_valid and out_err are driven directly from the final stage's registers.
- Latency: STAGES cycles from the in_valid&in_ready cycle to out_valid, when there is no backpressure.
- Throughput: 1 codeword per cycle.
- Advance rule:
  - stage_adv[STAGES-1] = !v[STAGES-1] | out_ready.
  - stage_adv[k] = !v[k] | stage_adv[k+1].
  - in_ready = stage_adv[0].
  - This is a combinational ready chain; there is no skid buffer.
- Transfer rule:
  - On stage_adv[k], stage k loads from stage k-1, or from the input for stage 0.
  - Its valid bit is set to the upstream valid; for stage 0 that is in_valid&in_ready.
  - When stage_adv[k] is low, stage k holds all its registers.
- Data handling:
  - Data registers of invalid stages may hold stale values. dataout is don't-care while out_valid=0.
  - dataout must remain stable while out_valid=1 and out_ready=0.
- Ordering: strictly FIFO. No codeword is dropped or duplicated under any out_ready pattern.
- in_valid=0 with in_ready=1: a bubble enters stage 0.
- Simultaneous accept and emit in the same cycle are supported at full occupancy when out_ready=1.
- Reset values: every stage valid=0, out_valid=0, in_ready=1 (it follows from the empty pipeline), dataout=0, out_err=0. Data registers are reset to 0.
- Reset mid-operation: all in-flight codewords are discarded. The cycle after rst deasserts, out_valid=0 and in_ready=1.
- The codein value is not required to be held after acceptance.
- STAGES=1 degenerates to a single registered decoder with latency 1.

Optional Feature:
- Macro: FNS_DEC_CHECK_EN.
- When defined:
  - Each stage also computes an error bit: 1 if any two adjacent codeword bits within its chunk are both 1, or if the last bit of the previous chunk and the first bit of this chunk are both 1.
  - The error bit is OR-ed along the pipeline. The boundary bit travels with the carried codeword.
  - The result is presented on out_err, aligned with dataout and subject to the same hold rule.
  - dataout is still the full weighted sum, not saturated.
- When undefined: out_err port and all check logic are absent. Ports and behaviour are otherwise identical.

Test Plan:
- Basic values (N=42, STAGES=3, out_ready=1):
  - codein=0 -> dataout=0, out_valid exactly 3 cycles after acceptance.
  - codein=42'h1 -> 1.
  - codein=42'h2 -> 2.
  - codein=42'h15 -> 12 (1+3+8).
- Extremes:
  - codein = bit 41 only -> 433494437.
  - codein = all ones -> 1134903168. This is the DW=31 boundary; no overflow.
- Streaming: 100 random codewords back-to-back with in_valid=1 -> outputs match a reference model in order, 1 per cycle, in_ready never drops.
- Backpressure:
  - Hold out_ready=0 for 6 cycles during streaming -> after 3 accepts, in_ready=0.
  - dataout stays stable while stalled.
  - Release -> no loss or duplication; order preserved.
- Reset: assert rst for 1 cycle with 3 codewords in flight -> next cycle out_valid=0 and in_ready=1; no stale value is emitted afterwards.
- With FNS_DEC_CHECK_EN:
  - codein=42'h3 -> dataout=3, out_err=1.
  - codein with bits 13 and 14 set (chunk boundary) -> out_err=1.
  - codein=42'h15 -> out_err=0.
- STAGES=1 and N=8: all 256 codewords decoded with latency 1.
